rgmii_tx_framer: RTL and testbench



---
 rtl/rgmii_pkg.sv | 49 ++++
 rtl/crc32_d8.sv | 41 ++++
 rtl/rgmii_tx_framer.sv | 190 +++++++++++++++++++
 tb/tb_rgmii_tx_framer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgmii_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rgmii_pkg
// Brief    : Shared types, byte constants and CRC-32 helpers for the RGMII
//            transmit framer.
// Revision : 1.0 - initial release
// ============================================================================
package rgmii_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_SFD  = 3'd2,
    ST_DATA = 3'd3,
    ST_PAD  = 3'd4,
    ST_FCS  = 3'd5,
    ST_IFG  = 3'd6
  } tx_state_e;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;

  localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

  // LSB-first (reflected) update: one data byte folded into the running CRC.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                             input logic [7:0]  data);
    logic [31:0] c;
    logic [31:0] p;
    p = reflect32(CRC_POLY);
    c = crc ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ p) : (c >> 1);
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/crc32_d8.sv
`default_nettype none
// ============================================================================
// Module   : crc32_d8
// Brief    : Byte-per-cycle reflected CRC-32 accumulator with clear/enable.
// Revision : 1.0 - initial release
// ============================================================================
module crc32_d8
  import rgmii_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  logic [31:0] crc_q;
  logic [31:0] crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clr_i) begin
      crc_d = CRC_INIT;
    end else if (en_i) begin
      crc_d = crc32_byte(crc_q, data_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      crc_q <= CRC_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule
`default_nettype wire

// File: rtl/rgmii_tx_framer.sv
`default_nettype none
// ============================================================================
// Module   : rgmii_tx_framer
// Brief    : GMII-side transmit sequencer: preamble/SFD, payload, padding,
//            optional FCS (define RGMII_TX_FCS_EN), inter-frame gap, underrun.
// Revision : 1.0 - initial release
// ============================================================================
module rgmii_tx_framer
  import rgmii_pkg::*;
#(
  parameter int IFG_CYCLES = 12,
  parameter int MIN_LEN    = 60,
  parameter int PRE_LEN    = 7
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] S_DATA,
  input  logic       S_VALID,
  input  logic       S_LAST,
  input  logic       S_ERR,
  output logic       S_READY,
  output logic [7:0] TXD_OUT,
  output logic       TX_EN,
  output logic       TX_ER,
  output logic       BUSY,
  output logic       FRAME_DONE,
  output logic       UNDERRUN
);

  localparam logic [15:0] PRE_LAST  = 16'(PRE_LEN - 1);
  localparam logic [15:0] IFG_LAST  = 16'(IFG_CYCLES - 1);
  localparam logic [15:0] MIN_LEN_W = 16'(MIN_LEN);

  tx_state_e   state_q;
  logic [15:0] count_q;
  logic [15:0] phase_q;
  logic        clean_q;

  logic [15:0] count_inc;
  logic        accept_phase;

  assign count_inc    = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
  assign accept_phase = (state_q == ST_SFD) || (state_q == ST_DATA);
  assign S_READY      = accept_phase;

`ifdef RGMII_TX_FCS_EN
  localparam tx_state_e TAIL_STATE = ST_FCS;

  logic [31:0] crc;
  logic [31:0] fcs_word;
  logic [7:0]  fcs_byte;
  logic        crc_clr;
  logic        crc_en;
  logic [7:0]  crc_data;

  assign crc_clr  = (state_q == ST_IDLE);
  assign crc_en   = (accept_phase && S_VALID) || (state_q == ST_PAD);
  assign crc_data = (state_q == ST_PAD) ? 8'h00 : S_DATA;
  assign fcs_word = ~crc;
  assign fcs_byte = fcs_word[{phase_q[1:0], 3'b000} +: 8];

  crc32_d8 u_crc (
    .clk_i  (CLK),
    .rst_ni (RST_N),
    .clr_i  (crc_clr),
    .en_i   (crc_en),
    .data_i (crc_data),
    .crc_o  (crc)
  );
`else
  localparam tx_state_e TAIL_STATE = ST_IFG;
`endif

  // Outputs are registered one step ahead: the state names what is on the
  // wire now, and each edge loads the byte that follows it.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      count_q    <= 16'd0;
      phase_q    <= 16'd0;
      clean_q    <= 1'b0;
      TXD_OUT    <= 8'h00;
      TX_EN      <= 1'b0;
      TX_ER      <= 1'b0;
      BUSY       <= 1'b0;
      FRAME_DONE <= 1'b0;
      UNDERRUN   <= 1'b0;
    end else begin
      FRAME_DONE <= 1'b0;
      UNDERRUN   <= 1'b0;
      TX_ER      <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          TX_EN   <= 1'b0;
          TXD_OUT <= 8'h00;
          if (S_VALID) begin
            state_q <= ST_PRE;
            phase_q <= 16'd0;
            count_q <= 16'd0;
            clean_q <= 1'b1;
            BUSY    <= 1'b1;
            TX_EN   <= 1'b1;
            TXD_OUT <= PREAMBLE_BYTE;
          end
        end

        ST_PRE: begin
          TX_EN <= 1'b1;
          if (phase_q == PRE_LAST) begin
            TXD_OUT <= SFD_BYTE;
            state_q <= ST_SFD;
          end else begin
            TXD_OUT <= PREAMBLE_BYTE;
            phase_q <= phase_q + 16'd1;
          end
        end

        ST_SFD, ST_DATA: begin
          TX_EN <= 1'b1;
          if (S_VALID) begin
            TXD_OUT <= S_DATA;
            TX_ER   <= S_ERR;
            count_q <= count_inc;
            state_q <= ST_DATA;
            if (S_LAST) begin
              if (count_inc < MIN_LEN_W) begin
                state_q <= ST_PAD;
              end else begin
                state_q <= TAIL_STATE;
                phase_q <= 16'd0;
              end
            end
          end else begin
            // Source starved mid-frame: poison the wire and abandon the frame.
            TXD_OUT  <= 8'h00;
            TX_ER    <= 1'b1;
            UNDERRUN <= 1'b1;
            clean_q  <= 1'b0;
            state_q  <= ST_IFG;
            phase_q  <= 16'd0;
          end
        end

        ST_PAD: begin
          TX_EN   <= 1'b1;
          TXD_OUT <= 8'h00;
          count_q <= count_inc;
          if (count_inc >= MIN_LEN_W) begin
            state_q <= TAIL_STATE;
            phase_q <= 16'd0;
          end
        end

`ifdef RGMII_TX_FCS_EN
        ST_FCS: begin
          TX_EN   <= 1'b1;
          TXD_OUT <= fcs_byte;
          if (phase_q[1:0] == 2'd3) begin
            state_q <= ST_IFG;
            phase_q <= 16'd0;
          end else begin
            phase_q <= phase_q + 16'd1;
          end
        end
`endif

        ST_IFG: begin
          TX_EN      <= 1'b0;
          TXD_OUT    <= 8'h00;
          FRAME_DONE <= clean_q && (phase_q == 16'd0);
          if (phase_q == IFG_LAST) begin
            state_q <= ST_IDLE;
            BUSY    <= 1'b0;
          end else begin
            phase_q <= phase_q + 16'd1;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          TX_EN   <= 1'b0;
          TXD_OUT <= 8'h00;
          BUSY    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rgmii_tx_framer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rgmii_tx_framer
// Brief    : Directed bench for rgmii_tx_framer; honours RGMII_TX_FCS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rgmii_tx_framer;

`ifdef RGMII_TX_FCS_EN
  localparam int FCS_LEN = 4;
`else
  localparam int FCS_LEN = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] S_DATA = 8'h00;
  logic       S_VALID = 1'b0;
  logic       S_LAST = 1'b0;
  logic       S_ERR = 1'b0;
  logic       S_READY;
  logic [7:0] TXD_OUT;
  logic       TX_EN;
  logic       TX_ER;
  logic       BUSY;
  logic       FRAME_DONE;
  logic       UNDERRUN;

  always #5 clk = ~clk;

  rgmii_tx_framer #(
    .IFG_CYCLES (12),
    .MIN_LEN    (60),
    .PRE_LEN    (7)
  ) dut (
    .CLK        (clk),
    .RST_N      (rst_n),
    .S_DATA     (S_DATA),
    .S_VALID    (S_VALID),
    .S_LAST     (S_LAST),
    .S_ERR      (S_ERR),
    .S_READY    (S_READY),
    .TXD_OUT    (TXD_OUT),
    .TX_EN      (TX_EN),
    .TX_ER      (TX_ER),
    .BUSY       (BUSY),
    .FRAME_DONE (FRAME_DONE),
    .UNDERRUN   (UNDERRUN)
  );

  int vec_cnt  = 0;
  int miss_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Per-cycle snapshot: {en, er, d[7:0], done, und, busy, rdy}
  typedef logic [13:0] cyc_t;
  typedef struct packed {
    logic [7:0] d;
    logic       last;
    logic       err;
  } beat_t;

  cyc_t  cap[$];
  cyc_t  exp_q[$];
  beat_t stim[$];
  bit    rec = 1'b0;

  always @(negedge clk) begin
    if (rec) cap.push_back({TX_EN, TX_ER, TXD_OUT, FRAME_DONE, UNDERRUN, BUSY, S_READY});
  end

  function automatic cyc_t mk(input bit en, input bit er, input logic [7:0] d,
                              input bit done, input bit und, input bit busy, input bit rdy);
    return {en, er, d, done, und, busy, rdy};
  endfunction

  function automatic logic [31:0] crc_bit(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[0] ^ b[i];
      r  = r >> 1;
      if (fb) r = r ^ 32'hEDB88320;
    end
    return r;
  endfunction

  task automatic model_ifg(input bit normal);
    for (int i = 0; i < 12; i++)
      exp_q.push_back(mk(1'b0, 1'b0, 8'h00, normal && (i == 0), 1'b0, i < 11, 1'b0));
  endtask

  // Appends one frame to both the stimulus and the expected wire image.
  task automatic model_frame(input int n, input int base, input int err_idx, input int cut);
    logic [31:0] crc;
    logic [31:0] fcs;
    logic [7:0]  d;
    crc = 32'hFFFFFFFF;
    for (int k = 0; k < n; k++) stim.push_back('{8'(base + k), k == n - 1, k == err_idx});
    for (int k = 0; k < 7; k++) exp_q.push_back(mk(1'b1, 1'b0, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0));
    exp_q.push_back(mk(1'b1, 1'b0, 8'hD5, 1'b0, 1'b0, 1'b1, 1'b1));
    if (cut >= 0) begin
      for (int k = 0; k < cut; k++)
        exp_q.push_back(mk(1'b1, k == err_idx, 8'(base + k), 1'b0, 1'b0, 1'b1, 1'b1));
      exp_q.push_back(mk(1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0));
      model_ifg(1'b0);
    end else begin
      for (int k = 0; k < n; k++) begin
        d = 8'(base + k);
        exp_q.push_back(mk(1'b1, k == err_idx, d, 1'b0, 1'b0, 1'b1, k < n - 1));
        crc = crc_bit(crc, d);
      end
      for (int k = n; k < 60; k++) begin
        exp_q.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0));
        crc = crc_bit(crc, 8'h00);
      end
      fcs = ~crc;
      for (int i = 0; i < FCS_LEN; i++)
        exp_q.push_back(mk(1'b1, 1'b0, fcs[8*i +: 8], 1'b0, 1'b0, 1'b1, 1'b0));
      model_ifg(1'b1);
    end
  endtask

  task automatic drive(input int stop_after);
    int   idx = 0;
    int   guard = 0;
    logic hs;
    while (idx < stim.size() && idx != stop_after && guard < 4000) begin
      S_VALID = 1'b1;
      S_DATA  = stim[idx].d;
      S_LAST  = stim[idx].last;
      S_ERR   = stim[idx].err;
      @(negedge clk);
      hs = S_READY;
      @(posedge clk);
      #1;
      if (hs) idx++;
      guard++;
    end
    S_VALID = 1'b0;
    S_LAST  = 1'b0;
    S_ERR   = 1'b0;
    S_DATA  = 8'h00;
    if (guard >= 4000) check("drive_timeout", guard, 0);
  endtask

  task automatic run_case(input string tag, input int stop_after);
    int   guard = 0;
    cyc_t m;
    for (int i = 0; i < 4; i++) exp_q.push_back('0);
    cap.delete();
    rec = 1'b1;
    drive(stop_after);
    while (cap.size() < exp_q.size() && guard < 2000) begin
      @(posedge clk);
      guard++;
    end
    #1;
    rec = 1'b0;
    if (cap.size() < exp_q.size()) check({tag, "_capture_timeout"}, cap.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
      m = exp_q[i][13] ? 14'h3FFF : 14'h300F;
      check($sformatf("%s_cyc%0d", tag, i), cap[i] & m, exp_q[i] & m);
    end
  endtask

  task automatic new_case();
    stim.delete();
    exp_q.delete();
    exp_q.push_back('0);
  endtask

  initial begin
    int          n_en;
    int          n_done;
    logic [31:0] r;
    logic [31:0] rr;

    #12;
    check("rst_txen",  TX_EN,      0);
    check("rst_txer",  TX_ER,      0);
    check("rst_txd",   TXD_OUT,    0);
    check("rst_ready", S_READY,    0);
    check("rst_busy",  BUSY,       0);
    check("rst_done",  FRAME_DONE, 0);
    check("rst_und",   UNDERRUN,   0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_busy", BUSY, 0);

    // 64-byte payload 0x00..0x3F, streamed back-to-back
    new_case();
    model_frame(64, 8'h00, -1, -1);
    run_case("f64", -1);
    n_en   = 0;
    n_done = 0;
    for (int i = 0; i < cap.size(); i++) begin
      n_en   += int'(cap[i][13]);
      n_done += int'(cap[i][3]);
    end
    check("f64_en_cycles", n_en, 72 + FCS_LEN);
    check("f64_done_count", n_done, 1);
    check("f64_done_pos", cap[1 + 72 + FCS_LEN][3], 1);
`ifdef RGMII_TX_FCS_EN
    r = 32'hFFFFFFFF;
    for (int i = 9; i < 9 + 64 + 4; i++) r = crc_bit(r, cap[i][11:4]);
    for (int i = 0; i < 32; i++) rr[i] = r[31-i];
    check("f64_residue", rr, 32'hC704DD7B);
`endif

    // Short payload padded to the minimum length
    new_case();
    model_frame(10, 8'hA0, -1, -1);
    run_case("f10", -1);

    // Two queued frames, bad byte 5 in the first
    new_case();
    model_frame(20, 8'h80, 5, -1);
    model_frame(60, 8'h10, -1, -1);
    run_case("q2", -1);

    // Source starves after 20 of 100 bytes
    new_case();
    model_frame(100, 8'h30, -1, 20);
    run_case("und", 20);

    // Reset in the middle of the payload
    S_VALID = 1'b1;
    S_DATA  = 8'hA5;
    S_LAST  = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("mid_pre_txen",  TX_EN,   1);
    check("mid_pre_ready", S_READY, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_txen",  TX_EN,   0);
    check("mid_txer",  TX_ER,   0);
    check("mid_ready", S_READY, 0);
    check("mid_txd",   TXD_OUT, 0);
    check("mid_busy",  BUSY,    0);
    S_VALID = 1'b0;
    S_DATA  = 8'h00;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_txen",  TX_EN,   0);
    check("post_busy",  BUSY,    0);
    check("post_ready", S_READY, 0);

    new_case();
    model_frame(60, 8'h40, -1, -1);
    run_case("rec", -1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
`default_nettype wire
